// File: rtl/apb_req_arbiter.sv
// apb_req_arbiter: two-requester APB master with round-robin arbitration,
// a bounded P_ready wait and per-requester done/rdata/err return.
module apb_req_arbiter #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic              P_clk,
  input  logic              P_rstn,
  input  logic              req0_valid,
  input  logic              req0_write,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_wdata,
  output logic              req0_ack,
  output logic              req0_done,
  output logic [DATA_W-1:0] req0_rdata,
  output logic              req0_err,
  input  logic              req1_valid,
  input  logic              req1_write,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_wdata,
  output logic              req1_ack,
  output logic              req1_done,
  output logic [DATA_W-1:0] req1_rdata,
  output logic              req1_err,
  output logic [ADDR_W-1:0] P_addr,
  output logic              P_selx,
  output logic              P_enable,
  output logic              P_write,
  output logic [DATA_W-1:0] P_wdata,
  input  logic              P_ready,
  input  logic              P_slverr,
  input  logic [DATA_W-1:0] P_rdata
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] WAIT_MAX = CNT_W'(TIMEOUT - 1);

  // S_GRANT is the ack cycle (bus still idle); state_q otherwise mirrors
  // the phase shown on the bus, so completion can re-arbitrate on the same
  // edge and the next ack lands in the done cycle.
  typedef enum logic [1:0] {
    S_IDLE,
    S_GRANT,
    S_SETUP,
    S_ACCESS
  } state_t;

  state_t              state_q;
  logic                last_grant_q;
  logic                gnt_q;
  logic [CNT_W-1:0]    wait_q;
  logic [ADDR_W-1:0]   addr_q;
  logic                selx_q;
  logic                enable_q;
  logic                write_q;
  logic [DATA_W-1:0]   wdata_q;
  logic                ack0_q, ack1_q, done0_q, done1_q, err0_q, err1_q;
  logic [DATA_W-1:0]   rdata0_q, rdata1_q;

  logic pick1;
  logic timeout_hit;
  logic complete;
  logic arb_go;

  // Arbitration choice and transfer-completion conditions
  always_comb begin
    pick1       = req1_valid & (~req0_valid | ~last_grant_q);
    timeout_hit = (wait_q == WAIT_MAX);
    complete    = (state_q == S_ACCESS) & (P_ready | timeout_hit);
    arb_go      = (req0_valid | req1_valid) & ((state_q == S_IDLE) | complete);
  end

  // Bus FSM, grant latch, wait counter and requester return registers
  always_ff @(posedge P_clk or negedge P_rstn) begin
    if (!P_rstn) begin
      state_q      <= S_IDLE;
      last_grant_q <= 1'b1;
      gnt_q        <= 1'b0;
      wait_q       <= '0;
      addr_q       <= '0;
      selx_q       <= 1'b0;
      enable_q     <= 1'b0;
      write_q      <= 1'b0;
      wdata_q      <= '0;
      ack0_q       <= 1'b0;
      ack1_q       <= 1'b0;
      done0_q      <= 1'b0;
      done1_q      <= 1'b0;
      err0_q       <= 1'b0;
      err1_q       <= 1'b0;
      rdata0_q     <= '0;
      rdata1_q     <= '0;
    end else begin
      ack0_q  <= 1'b0;
      ack1_q  <= 1'b0;
      done0_q <= 1'b0;
      done1_q <= 1'b0;
      case (state_q)
        S_GRANT: begin
          selx_q  <= 1'b1;
          state_q <= S_SETUP;
        end
        S_SETUP: begin
          enable_q <= 1'b1;
          state_q  <= S_ACCESS;
        end
        S_ACCESS: begin
          if (complete) begin
            selx_q   <= 1'b0;
            enable_q <= 1'b0;
            wait_q   <= '0;
            state_q  <= S_IDLE;
            if (gnt_q) begin
              done1_q <= 1'b1;
              err1_q  <= ~P_ready | P_slverr;
              if (P_ready && !write_q) rdata1_q <= P_rdata;
            end else begin
              done0_q <= 1'b1;
              err0_q  <= ~P_ready | P_slverr;
              if (P_ready && !write_q) rdata0_q <= P_rdata;
            end
          end else begin
            wait_q <= wait_q + CNT_W'(1);
          end
        end
        default: ;
      endcase
      if (arb_go) begin
        gnt_q        <= pick1;
        last_grant_q <= pick1;
        ack0_q       <= ~pick1;
        ack1_q       <= pick1;
        write_q      <= pick1 ? req1_write : req0_write;
        addr_q       <= pick1 ? req1_addr  : req0_addr;
        wdata_q      <= pick1 ? req1_wdata : req0_wdata;
        state_q      <= S_GRANT;
      end
    end
  end

  assign req0_ack   = ack0_q;
  assign req0_done  = done0_q;
  assign req0_rdata = rdata0_q;
  assign req0_err   = err0_q;
  assign req1_ack   = ack1_q;
  assign req1_done  = done1_q;
  assign req1_rdata = rdata1_q;
  assign req1_err   = err1_q;
  assign P_addr     = addr_q;
  assign P_selx     = selx_q;
  assign P_enable   = enable_q;
  assign P_write    = write_q;
  assign P_wdata    = wdata_q;

endmodule

// File: tb/tb_apb_req_arbiter.sv
// Bench for apb_req_arbiter: APB slave model with configurable wait states,
// plus a transaction-level reference model of arbitration, timing and data.
module tb_apb_req_arbiter;

  localparam int TIMEOUT = 16;

  logic        P_clk = 1'b0;
  logic        P_rstn = 1'b0;
  logic        req0_valid = 1'b0, req0_write = 1'b0;
  logic [31:0] req0_addr = '0, req0_wdata = '0;
  logic        req1_valid = 1'b0, req1_write = 1'b0;
  logic [31:0] req1_addr = '0, req1_wdata = '0;
  logic        req0_ack, req0_done, req0_err, req1_ack, req1_done, req1_err;
  logic [31:0] req0_rdata, req1_rdata;
  logic [31:0] P_addr, P_wdata;
  logic        P_selx, P_enable, P_write;
  logic        P_ready = 1'b0, P_slverr = 1'b0;
  logic [31:0] P_rdata = '0;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  apb_req_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TIMEOUT)) dut (
    .P_clk(P_clk), .P_rstn(P_rstn),
    .req0_valid(req0_valid), .req0_write(req0_write), .req0_addr(req0_addr),
    .req0_wdata(req0_wdata), .req0_ack(req0_ack), .req0_done(req0_done),
    .req0_rdata(req0_rdata), .req0_err(req0_err),
    .req1_valid(req1_valid), .req1_write(req1_write), .req1_addr(req1_addr),
    .req1_wdata(req1_wdata), .req1_ack(req1_ack), .req1_done(req1_done),
    .req1_rdata(req1_rdata), .req1_err(req1_err),
    .P_addr(P_addr), .P_selx(P_selx), .P_enable(P_enable), .P_write(P_write),
    .P_wdata(P_wdata), .P_ready(P_ready), .P_slverr(P_slverr), .P_rdata(P_rdata)
  );

  always #5 P_clk = ~P_clk;
  always @(posedge P_clk) cyc = cyc + 1;

  // Slave model: ready after slv_waits ACCESS cycles; junk on unqualified lines.
  int          slv_waits = 0;
  logic        slv_err = 1'b0;
  logic        slv_junk = 1'b0;
  int          acc_n = 0;
  logic [31:0] mem [16];
  logic [31:0] junk;
  always @(negedge P_clk) begin
    junk = $urandom;
    if (P_selx && P_enable) begin
      acc_n = acc_n + 1;
      if (acc_n > slv_waits) begin
        P_ready  = 1'b1;
        P_slverr = slv_err;
        if (P_write) begin
          mem[P_addr[3:0]] = P_wdata;
          P_rdata = junk;
        end else begin
          P_rdata = mem[P_addr[3:0]];
        end
      end else begin
        P_ready  = 1'b0;
        P_slverr = slv_junk | junk[0];
        P_rdata  = junk;
      end
    end else begin
      acc_n    = 0;
      P_ready  = 1'b0;
      P_slverr = junk[1];
      P_rdata  = junk;
    end
  end

  // Reference model state
  logic [31:0] ref_mem [16];
  logic [31:0] exp_rd [2];
  int          exp_last;

  typedef struct {
    int          done_c;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  typedef struct {
    int          ack_c, setup_c, access_c, done_c, n_setup;
    logic [31:0] rdata;
    logic        err;
    bit          bus_ok, other_ok;
  } obs_t;

  // Transaction-level prediction: timing from waits vs TIMEOUT, data from ref_mem.
  function automatic exp_t predict(input int p, input logic wr, input logic [31:0] a,
                                   input logic [31:0] d, input int w, input logic serr,
                                   input int ack_c);
    exp_t e;
    bit   to;
    to       = (w >= TIMEOUT);
    e.done_c = to ? ack_c + 2 + TIMEOUT : ack_c + 3 + w;
    e.err    = to ? 1'b1 : serr;
    if (!to && !wr) exp_rd[p] = ref_mem[a[3:0]];
    if (!to && wr)  ref_mem[a[3:0]] = d;
    e.rdata  = exp_rd[p];
    exp_last = p;
    return e;
  endfunction

  task automatic set_req(input int p, input logic v, input logic wr,
                         input logic [31:0] a, input logic [31:0] d);
    if (p == 0) begin
      req0_valid = v; req0_write = wr; req0_addr = a; req0_wdata = d;
    end else begin
      req1_valid = v; req1_write = wr; req1_addr = a; req1_wdata = d;
    end
  endtask

  // Issue one command on port p and record what the DUT does with it.
  task automatic do_xfer(input int p, input logic wr, input logic [31:0] a,
                         input logic [31:0] d, output obs_t o, output int drive_c);
    logic [31:0] orx, r;
    logic        oerr;
    o.ack_c = -1; o.setup_c = -1; o.access_c = -1; o.done_c = -1; o.n_setup = 0;
    o.rdata = '0; o.err = 1'b0; o.bus_ok = 1; o.other_ok = 1;
    @(negedge P_clk);
    orx  = (p == 0) ? req1_rdata : req0_rdata;
    oerr = (p == 0) ? req1_err : req0_err;
    set_req(p, 1'b1, wr, a, d);
    drive_c = cyc;
    for (int i = 0; i < 200 && o.done_c < 0; i++) begin
      @(negedge P_clk);
      if (o.ack_c < 0 && ((p == 0) ? req0_ack : req1_ack)) begin
        o.ack_c = cyc;
        r = $urandom;
        set_req(p, 1'b0, ~wr, r, ~r);
      end
      if ((p == 0) ? (req1_ack | req1_done | (req1_rdata !== orx) | (req1_err !== oerr))
                   : (req0_ack | req0_done | (req0_rdata !== orx) | (req0_err !== oerr)))
        o.other_ok = 0;
      if (P_selx === 1'b1) begin
        if (P_addr !== a || P_write !== wr || (wr && P_wdata !== d)) o.bus_ok = 0;
        if (P_enable === 1'b0) begin
          o.n_setup++;
          if (o.setup_c < 0) o.setup_c = cyc;
        end else if (o.access_c < 0) begin
          o.access_c = cyc;
        end
      end else if (P_enable !== 1'b0) begin
        o.bus_ok = 0;
      end
      if ((p == 0) ? req0_done : req1_done) begin
        o.done_c = cyc;
        o.rdata  = (p == 0) ? req0_rdata : req1_rdata;
        o.err    = (p == 0) ? req0_err : req1_err;
      end
    end
  endtask

  task automatic test_reset();
    P_rstn = 1'b0;
    repeat (3) @(negedge P_clk);
    checks++;
    if ({req0_ack, req0_done, req0_rdata, req0_err, req1_ack, req1_done, req1_rdata, req1_err,
         P_addr, P_selx, P_enable, P_write, P_wdata} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got selx=%b en=%b addr=%h ack=%b%b done=%b%b, required all 0",
               P_selx, P_enable, P_addr, req0_ack, req1_ack, req0_done, req1_done);
    end
    P_rstn = 1'b1;
    exp_rd[0] = '0; exp_rd[1] = '0; exp_last = 1;
  endtask

  task automatic test_basic_write();
    obs_t o; exp_t e; int dc;
    slv_waits = 0; slv_err = 1'b0; slv_junk = 1'b0;
    do_xfer(0, 1'b1, 32'd1, 32'd7, o, dc);
    e = predict(0, 1'b1, 32'd1, 32'd7, 0, 1'b0, o.ack_c);
    checks++; if (o.ack_c !== dc + 1) begin errors++; $display("FAIL basic_ack_cycle: got %0d required %0d", o.ack_c, dc + 1); end
    checks++; if (o.setup_c !== o.ack_c + 1 || o.n_setup !== 1) begin errors++; $display("FAIL basic_setup: got cyc %0d n=%0d required %0d n=1", o.setup_c, o.n_setup, o.ack_c + 1); end
    checks++; if (o.access_c !== o.ack_c + 2) begin errors++; $display("FAIL basic_access: got %0d required %0d", o.access_c, o.ack_c + 2); end
    checks++; if (o.done_c !== e.done_c) begin errors++; $display("FAIL basic_done_cycle: got %0d required %0d", o.done_c, e.done_c); end
    checks++; if (o.err !== e.err) begin errors++; $display("FAIL basic_err: got %b required %b", o.err, e.err); end
    checks++; if (!o.bus_ok || !o.other_ok) begin errors++; $display("FAIL basic_bus: got bus_ok=%0d other_ok=%0d required 1 1", o.bus_ok, o.other_ok); end
  endtask

  task automatic test_wait_read();
    obs_t o; exp_t e; int dc;
    slv_waits = 2;
    do_xfer(1, 1'b0, 32'd1, 32'h0, o, dc);
    e = predict(1, 1'b0, 32'd1, 32'h0, 2, 1'b0, o.ack_c);
    checks++; if (o.done_c !== o.access_c + 3 || o.done_c !== e.done_c) begin errors++; $display("FAIL wait_done_cycle: got %0d required %0d", o.done_c, e.done_c); end
    checks++; if (o.rdata !== e.rdata || o.rdata !== 32'd7) begin errors++; $display("FAIL wait_rdata: got %h required %h", o.rdata, e.rdata); end
    checks++; if (o.err !== 1'b0 || !o.bus_ok || !o.other_ok) begin errors++; $display("FAIL wait_err_bus: got err=%b bus=%0d other=%0d required 0 1 1", o.err, o.bus_ok, o.other_ok); end
  endtask

  task automatic test_slverr();
    obs_t o; exp_t e; int dc;
    slv_waits = 0; slv_err = 1'b1; slv_junk = 1'b0;
    do_xfer(0, 1'b0, 32'd5, 32'h0, o, dc);
    e = predict(0, 1'b0, 32'd5, 32'h0, 0, 1'b1, o.ack_c);
    checks++; if (o.err !== 1'b1 || o.done_c !== e.done_c) begin errors++; $display("FAIL slverr_err: got err=%b at %0d required 1 at %0d", o.err, o.done_c, e.done_c); end
    checks++; if (o.rdata !== e.rdata) begin errors++; $display("FAIL slverr_rdata: got %h required %h", o.rdata, e.rdata); end
    slv_waits = 3; slv_err = 1'b0; slv_junk = 1'b1;
    do_xfer(1, 1'b0, 32'd5, 32'h0, o, dc);
    e = predict(1, 1'b0, 32'd5, 32'h0, 3, 1'b0, o.ack_c);
    checks++; if (o.err !== 1'b0 || o.done_c !== e.done_c) begin errors++; $display("FAIL slverr_ignored: got err=%b at %0d required 0 at %0d", o.err, o.done_c, e.done_c); end
    checks++; if (o.rdata !== e.rdata) begin errors++; $display("FAIL slverr_ignored_rdata: got %h required %h", o.rdata, e.rdata); end
    slv_junk = 1'b0;
  endtask

  task automatic test_timeout();
    obs_t o; exp_t e; int dc;
    slv_waits = 1000; slv_err = 1'b0;
    do_xfer(0, 1'b0, 32'd3, 32'h0, o, dc);
    e = predict(0, 1'b0, 32'd3, 32'h0, 1000, 1'b0, o.ack_c);
    checks++; if (o.done_c !== e.done_c) begin errors++; $display("FAIL timeout_cycle: got %0d required %0d", o.done_c, e.done_c); end
    checks++; if (o.err !== 1'b1 || o.rdata !== e.rdata) begin errors++; $display("FAIL timeout_err: got err=%b rdata=%h required 1 %h", o.err, o.rdata, e.rdata); end
    slv_waits = 0;
    do_xfer(1, 1'b1, 32'd3, 32'hA5A5_0003, o, dc);
    e = predict(1, 1'b1, 32'd3, 32'hA5A5_0003, 0, 1'b0, o.ack_c);
    checks++; if (o.ack_c !== dc + 1 || o.done_c !== e.done_c || o.err !== 1'b0) begin errors++; $display("FAIL after_timeout: got ack %0d done %0d err %b required %0d %0d 0", o.ack_c, o.done_c, o.err, dc + 1, e.done_c); end
    slv_waits = TIMEOUT - 1;
    do_xfer(0, 1'b0, 32'd3, 32'h0, o, dc);
    e = predict(0, 1'b0, 32'd3, 32'h0, TIMEOUT - 1, 1'b0, o.ack_c);
    checks++; if (o.done_c !== e.done_c || o.err !== 1'b0 || o.rdata !== e.rdata) begin errors++; $display("FAIL ready_at_limit: got done %0d err %b rdata %h required %0d 0 %h", o.done_c, o.err, o.rdata, e.done_c, e.rdata); end
    slv_waits = 0;
  endtask

  task automatic test_random();
    obs_t o; exp_t e; int dc, p, w; logic wr, serr; logic [31:0] a, d, r;
    for (int n = 0; n < 24; n++) begin
      r = $urandom;
      p = int'(r[0]); wr = r[1]; serr = r[2] & r[3];
      w = $urandom_range(0, 4);
      a = 32'($urandom_range(0, 15)); d = $urandom;
      slv_waits = w; slv_err = serr;
      do_xfer(p, wr, a, d, o, dc);
      e = predict(p, wr, a, d, w, serr, o.ack_c);
      checks++;
      if (o.ack_c !== dc + 1 || o.done_c !== e.done_c || o.err !== e.err || o.rdata !== e.rdata ||
          !o.bus_ok || !o.other_ok || o.n_setup !== 1) begin
        errors++;
        $display("FAIL random_xfer[%0d]: got ack %0d done %0d err %b rdata %h bus %0d other %0d; required ack %0d done %0d err %b rdata %h",
                 n, o.ack_c, o.done_c, o.err, o.rdata, o.bus_ok, o.other_ok, dc + 1, e.done_c, e.err, e.rdata);
      end
    end
    slv_waits = 0; slv_err = 1'b0;
  endtask

  task automatic test_back_to_back();
    int w, n_ack, last_ack, gp, exp_p, dp;
    int q_port[$], q_cyc[$];
    logic [31:0] q_rd[$];
    logic cw [2]; logic [31:0] ca [2], cd [2]; logic [31:0] r;
    exp_t e;
    w = $urandom_range(0, 2); slv_waits = w; slv_err = 1'b0;
    @(negedge P_clk);
    for (int p = 0; p < 2; p++) begin
      r = $urandom; cw[p] = r[0]; ca[p] = 32'($urandom_range(0, 15)); cd[p] = $urandom;
      set_req(p, 1'b1, cw[p], ca[p], cd[p]);
    end
    n_ack = 0; last_ack = -1;
    for (int i = 0; i < 300 && (n_ack < 8 || q_port.size() > 0); i++) begin
      @(negedge P_clk);
      if (req0_ack || req1_ack) begin
        gp = req1_ack ? 1 : 0;
        exp_p = 1 - exp_last;
        checks++;
        if ((req0_ack && req1_ack) || gp !== exp_p) begin errors++; $display("FAIL b2b_grant[%0d]: got ack0=%b ack1=%b required port %0d", n_ack, req0_ack, req1_ack, exp_p); end
        if (last_ack >= 0) begin
          checks++;
          if (cyc - last_ack !== 3 + w) begin errors++; $display("FAIL b2b_spacing[%0d]: got %0d required %0d", n_ack, cyc - last_ack, 3 + w); end
        end
        e = predict(exp_p, cw[exp_p], ca[exp_p], cd[exp_p], w, 1'b0, cyc);
        q_port.push_back(exp_p); q_cyc.push_back(e.done_c); q_rd.push_back(e.rdata);
        last_ack = cyc; n_ack++;
        if (n_ack < 8) begin
          r = $urandom; cw[gp] = r[0]; ca[gp] = 32'($urandom_range(0, 15)); cd[gp] = $urandom;
          set_req(gp, 1'b1, cw[gp], ca[gp], cd[gp]);
        end else begin
          set_req(0, 1'b0, 1'b0, '0, '0);
          set_req(1, 1'b0, 1'b0, '0, '0);
        end
      end
      if (req0_done || req1_done) begin
        dp = req1_done ? 1 : 0;
        checks++;
        if (q_port.size() == 0) begin
          errors++; $display("FAIL b2b_done: got unexpected done on port %0d required none", dp);
        end else begin
          if ((req0_done && req1_done) || dp !== q_port[0] || cyc !== q_cyc[0] ||
              ((dp == 0) ? req0_rdata : req1_rdata) !== q_rd[0] || ((dp == 0) ? req0_err : req1_err) !== 1'b0) begin
            errors++;
            $display("FAIL b2b_done: got port %0d cyc %0d rdata %h; required port %0d cyc %0d rdata %h err 0",
                     dp, cyc, (dp == 0) ? req0_rdata : req1_rdata, q_port[0], q_cyc[0], q_rd[0]);
          end
          void'(q_port.pop_front()); void'(q_cyc.pop_front()); void'(q_rd.pop_front());
        end
      end
    end
    checks++;
    if (n_ack !== 8 || q_port.size() !== 0) begin errors++; $display("FAIL b2b_complete: got %0d acks %0d pending required 8 acks 0 pending", n_ack, q_port.size()); end
    slv_waits = 0;
  endtask

  task automatic test_reset_mid();
    exp_t e; int dc, done_c; bit stray;
    slv_waits = 1000;
    @(negedge P_clk);
    set_req(0, 1'b1, 1'b1, 32'd9, 32'h55);
    for (int i = 0; i < 20 && P_enable !== 1'b1; i++) begin
      @(negedge P_clk);
      if (req0_ack) set_req(0, 1'b0, 1'b0, '0, '0);
    end
    #2 P_rstn = 1'b0;
    #1;
    checks++;
    if ({req0_ack, req0_done, req0_rdata, req0_err, req1_ack, req1_done, req1_rdata, req1_err,
         P_addr, P_selx, P_enable, P_write, P_wdata} !== '0) begin
      errors++;
      $display("FAIL async_reset: got selx=%b en=%b addr=%h done=%b%b, required all 0", P_selx, P_enable, P_addr, req0_done, req1_done);
    end
    @(negedge P_clk); @(negedge P_clk);
    P_rstn = 1'b1;
    exp_rd[0] = '0; exp_rd[1] = '0; exp_last = 1; slv_waits = 0;
    @(negedge P_clk);
    set_req(0, 1'b1, 1'b1, 32'd2, 32'h1111_2222);
    set_req(1, 1'b1, 1'b1, 32'd4, 32'h3333_4444);
    dc = cyc;
    @(negedge P_clk);
    checks++;
    if (req0_ack !== 1'b1 || req1_ack !== 1'b0 || cyc !== dc + 1) begin errors++; $display("FAIL tie_after_reset: got ack0=%b ack1=%b required 1 0", req0_ack, req1_ack); end
    e = predict(0, 1'b1, 32'd2, 32'h1111_2222, 0, 1'b0, cyc);
    set_req(0, 1'b0, 1'b0, '0, '0);
    set_req(1, 1'b0, 1'b0, '0, '0);
    done_c = -1; stray = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge P_clk);
      if (req1_ack || req1_done || req0_ack) stray = 1;
      if (req0_done) begin
        if (done_c >= 0) stray = 1;
        done_c = cyc;
      end
    end
    checks++;
    if (done_c !== e.done_c || stray) begin errors++; $display("FAIL after_reset_xfer: got done %0d stray %0d required done %0d stray 0", done_c, stray, e.done_c); end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) begin
      mem[i] = $urandom;
      ref_mem[i] = mem[i];
    end
    test_reset();
    test_basic_write();
    test_wait_read();
    test_slverr();
    test_timeout();
    test_random();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
